// File: rtl/bpt_tbp_pkg.sv
// Shared types and the 2-bit saturating counter transition for the branch prediction table.
package bpt_tbp_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bpt_state_t;

    localparam int BPT_ENTRIES_DEFAULT = 2048;

    localparam logic [1:0] RES_TAKEN     = 2'b10;
    localparam logic [1:0] RES_NOT_TAKEN = 2'b01;

    // Outcome codes 2'b00 and 2'b11 are malformed and leave the counter untouched.
    function automatic bpt_state_t bpt_next(input bpt_state_t state, input logic [1:0] taken_res);
        bpt_state_t nxt;
        nxt = state;
        case (taken_res)
            RES_TAKEN: begin
                case (state)
                    STRONG_NT:                  nxt = WEAK_NT;
                    WEAK_NT, WEAK_T, STRONG_T:  nxt = STRONG_T;
                    default:                    nxt = state;
                endcase
            end
            RES_NOT_TAKEN: begin
                case (state)
                    STRONG_T:                   nxt = WEAK_T;
                    WEAK_T, WEAK_NT, STRONG_NT: nxt = STRONG_NT;
                    default:                    nxt = state;
                endcase
            end
            default: nxt = state;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bpt_tbp_if.sv
// Fetch-side lookup and resolve-side update signals of the branch prediction table.
interface bpt_tbp_if;
    import bpt_tbp_pkg::*;

    word_t      pc_fetch;
    logic       taken_fetch;
    word_t      pc_res;
    logic [1:0] taken_res;
    logic       enable_res;

    modport bpt_tbp (
        input  pc_fetch,
        input  pc_res,
        input  taken_res,
        input  enable_res,
        output taken_fetch
    );

    modport tb (
        output pc_fetch,
        output pc_res,
        output taken_res,
        output enable_res,
        input  taken_fetch
    );

endinterface

// File: rtl/bpt_tbp.sv
// Two-bit saturating counter branch predictor: combinational lookup for fetch,
// single-entry registered update from the resolve stage.
module bpt_tbp
    import bpt_tbp_pkg::*;
#(
    parameter int BPT_ENTRIES = BPT_ENTRIES_DEFAULT,
    parameter int IDX_W       = $clog2(BPT_ENTRIES)
) (
    input  logic       CLK,
    input  logic       nRST,
    bpt_tbp_if.bpt_tbp bpt_tbpif
);

    bpt_state_t [BPT_ENTRIES-1:0] cnt_q;
    logic [IDX_W-1:0]             fetch_idx_s;
    logic [IDX_W-1:0]             res_idx_s;
    bpt_state_t                   cur_s;
    bpt_state_t                   nxt_d;
    logic                         unused_s;

    // Word-aligned indexing; high PC bits alias onto the same counter.
    always_comb begin
        fetch_idx_s = bpt_tbpif.pc_fetch[IDX_W+1:2];
        res_idx_s   = bpt_tbpif.pc_res[IDX_W+1:2];
        cur_s       = cnt_q[res_idx_s];
        nxt_d       = bpt_next(cur_s, bpt_tbpif.taken_res);
    end

    // Counter array: async clear to STRONG_NT, one indexed entry written per enabled cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BPT_ENTRIES; i++) begin
                cnt_q[i] <= STRONG_NT;
            end
        end else if (bpt_tbpif.enable_res) begin
            cnt_q[res_idx_s] <= nxt_d;
        end
    end

    // No bypass: a same-cycle write to the fetched entry is seen only after the edge.
    assign bpt_tbpif.taken_fetch = cnt_q[fetch_idx_s][1];

    assign unused_s = ^{bpt_tbpif.pc_fetch[31:IDX_W+2], bpt_tbpif.pc_fetch[1:0],
                        bpt_tbpif.pc_res[31:IDX_W+2],   bpt_tbpif.pc_res[1:0]};

endmodule

// File: tb/tb_bpt_tbp.sv
// Scoreboard bench for bpt_tbp: expected predictions are queued from a reference
// counter model when a lookup is driven and compared when taken_fetch is sampled.
module tb_bpt_tbp;

    localparam int N = 2048;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;
    logic [1:0] model [N];
    logic       exp_q [$];

    bpt_tbp_if bif ();

    bpt_tbp dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bpt_tbpif (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [1:0] ref_next(input logic [1:0] s, input logic [1:0] res);
        if (res == 2'b10) return (s == 2'b00) ? 2'b01 : 2'b11;
        if (res == 2'b01) return (s == 2'b11) ? 2'b10 : 2'b00;
        return s;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[12:2]);
    endfunction

    // Stimulus only: one resolution per cycle, model advanced for the same edge.
    task automatic drive_update(input logic [31:0] pc, input logic [1:0] res, input logic en);
        @(negedge CLK);
        bif.pc_res     = pc;
        bif.taken_res  = res;
        bif.enable_res = en;
        if (en) model[idx_of(pc)] = ref_next(model[idx_of(pc)], res);
        @(negedge CLK);
        bif.enable_res = 1'b0;
    endtask

    task automatic sweep_update(input logic [1:0] res);
        for (int i = 0; i < N; i++) begin
            @(negedge CLK);
            bif.pc_res     = 32'(i) << 2;
            bif.taken_res  = res;
            bif.enable_res = 1'b1;
            model[i] = ref_next(model[i], res);
        end
        @(negedge CLK);
        bif.enable_res = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bif.pc_fetch = pc;
        exp_q.push_back(model[idx_of(pc)][1]);
        #1;
    endtask

    task automatic test_reset();
        logic e;
        nRST = 1'b0;
        bif.pc_fetch = '0; bif.pc_res = '0; bif.taken_res = 2'b00; bif.enable_res = 1'b0;
        foreach (model[i]) model[i] = 2'b00;
        #12;
        lookup(32'h0000_0040);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e) begin
            errors++; $display("FAIL reset_during got=%b exp=%b", bif.taken_fetch, e);
        end
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge CLK);
            lookup(32'(i) << 2);
            e = exp_q.pop_front(); checks++;
            if (bif.taken_fetch !== e || e !== 1'b0) begin
                errors++; $display("FAIL reset_sweep idx=%0d got=%b exp=0", i, bif.taken_fetch);
            end
        end
    endtask

    task automatic test_taken_sweeps();
        logic e;
        for (int pass = 0; pass < 2; pass++) begin
            sweep_update(2'b10);
            for (int i = 0; i < N; i++) begin
                @(negedge CLK);
                lookup(32'(i) << 2);
                e = exp_q.pop_front(); checks++;
                if (bif.taken_fetch !== e) begin
                    errors++; $display("FAIL taken_sweep%0d idx=%0d got=%b exp=%b", pass, i, bif.taken_fetch, e);
                end
            end
        end
    endtask

    task automatic test_not_taken_sweeps();
        logic e;
        for (int pass = 0; pass < 3; pass++) begin
            sweep_update(2'b01);
            for (int i = 0; i < N; i++) begin
                @(negedge CLK);
                lookup(32'(i) << 2);
                e = exp_q.pop_front(); checks++;
                if (bif.taken_fetch !== e) begin
                    errors++; $display("FAIL nt_sweep%0d idx=%0d got=%b exp=%b", pass, i, bif.taken_fetch, e);
                end
            end
        end
        // Saturation at strong-taken: extra taken then one not-taken must still predict taken.
        drive_update(32'h14, 2'b10, 1'b1);
        drive_update(32'h14, 2'b10, 1'b1);
        drive_update(32'h14, 2'b10, 1'b1);
        drive_update(32'h14, 2'b01, 1'b1);
        lookup(32'h14);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b1) begin
            errors++; $display("FAIL taken_saturate got=%b exp=1", bif.taken_fetch);
        end
    endtask

    task automatic test_hold_and_alias();
        logic e;
        drive_update(32'h40, 2'b10, 1'b1);
        for (int k = 0; k < 3; k++) drive_update(32'h40, 2'b10, 1'b0);
        lookup(32'h40);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b0) begin
            errors++; $display("FAIL enable_low_hold got=%b exp=0", bif.taken_fetch);
        end
        drive_update(32'h40, 2'b11, 1'b1);
        drive_update(32'h40, 2'b00, 1'b1);
        lookup(32'h40);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b0) begin
            errors++; $display("FAIL invalid_res_hold got=%b exp=0", bif.taken_fetch);
        end
        drive_update(32'h40, 2'b10, 1'b1);
        lookup(32'h40);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b1) begin
            errors++; $display("FAIL hold_then_taken got=%b exp=1", bif.taken_fetch);
        end
        drive_update(32'h2004, 2'b10, 1'b1);
        drive_update(32'h2004, 2'b10, 1'b1);
        lookup(32'h0004);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b1) begin
            errors++; $display("FAIL alias_read got=%b exp=1", bif.taken_fetch);
        end
        lookup(32'h0008);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b0) begin
            errors++; $display("FAIL neighbour_untouched got=%b exp=0", bif.taken_fetch);
        end
    endtask

    task automatic test_same_cycle();
        logic e;
        drive_update(32'h100, 2'b10, 1'b1);
        @(negedge CLK);
        bif.pc_fetch   = 32'h100;
        bif.pc_res     = 32'h100;
        bif.taken_res  = 2'b10;
        bif.enable_res = 1'b1;
        exp_q.push_back(model[64][1]);
        model[64] = ref_next(model[64], 2'b10);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b0) begin
            errors++; $display("FAIL same_cycle_pre got=%b exp=0", bif.taken_fetch);
        end
        exp_q.push_back(model[64][1]);
        @(posedge CLK);
        #1;
        bif.enable_res = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b1) begin
            errors++; $display("FAIL same_cycle_post got=%b exp=1", bif.taken_fetch);
        end
    endtask

    task automatic test_async_reset();
        logic e;
        for (int i = 0; i < 8; i++) begin
            drive_update(32'(i) << 2, 2'b10, 1'b1);
            drive_update(32'(i) << 2, 2'b10, 1'b1);
        end
        lookup(32'h1C);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e || e !== 1'b1) begin
            errors++; $display("FAIL pre_reset_taken got=%b exp=1", bif.taken_fetch);
        end
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        foreach (model[i]) model[i] = 2'b00;
        for (int i = 0; i < 8; i++) begin
            lookup(32'(i) << 2);
            e = exp_q.pop_front(); checks++;
            if (bif.taken_fetch !== e) begin
                errors++; $display("FAIL async_reset idx=%0d got=%b exp=%b", i, bif.taken_fetch, e);
            end
        end
        @(negedge CLK);
        nRST = 1'b1;
        lookup(32'h0004);
        e = exp_q.pop_front(); checks++;
        if (bif.taken_fetch !== e) begin
            errors++; $display("FAIL alias_after_reset got=%b exp=%b", bif.taken_fetch, e);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_taken_sweeps();
        test_not_taken_sweeps();
        test_hold_and_alias();
        test_same_cycle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
